// File: rtl/harq_llr_combiner_pkg.sv
// Shared widths, FSM state encoding and pipeline stage record for the HARQ LLR combiner.
package harq_llr_combiner_pkg;

    localparam int LLR_W      = 6;
    localparam int LANES      = 16;
    localparam int ADDR_W     = 11;
    localparam int WORD_W     = LLR_W * LANES;
    localparam int RAM_ADDR_W = ADDR_W + 1;
    localparam int SAT_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [RAM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } stage_t;

endpackage

// File: rtl/harq_llr_combiner_llr_sat_add.sv
// One lane of the combiner: two's-complement LLR add in LLR_W+1 bits, clamped to the LLR_W range.
module llr_sat_add
    import harq_llr_combiner_pkg::*;
(
    input  logic [LLR_W-1:0] i_old,
    input  logic [LLR_W-1:0] i_new,
    output logic [LLR_W-1:0] o_sum,
    output logic             o_sat
);

    logic [LLR_W:0] wide;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wide  = {i_old[LLR_W-1], i_old} + {i_new[LLR_W-1], i_new};
        o_sat = wide[LLR_W] ^ wide[LLR_W-1];
        o_sum = wide[LLR_W-1:0];
        if (o_sat) begin
            // Sign of the wide result tells which rail was crossed.
            o_sum = wide[LLR_W] ? {1'b1, {(LLR_W-1){1'b0}}} : {1'b0, {(LLR_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/harq_llr_combiner.sv
// HARQ soft-buffer LLR combiner: fill/combine write pipeline with read-first RAM hazard forwarding.
// Build option: define HARQ_SAT_CNT_EN to add the o_sat_count saturated-word counter.
module harq_llr_combiner
    import harq_llr_combiner_pkg::*;
(
    input  logic                  i_core_clk,
    input  logic                  i_rx_rstn,
    input  logic                  i_start,
    input  logic                  i_mode_combine,
    input  logic                  i_pingpong,
    input  logic                  i_data_valid,
    input  logic [WORD_W-1:0]     i_data,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_last,
    output logic                  o_ram_rd_en,
    output logic [RAM_ADDR_W-1:0] o_ram_rd_addr,
    input  logic [WORD_W-1:0]     i_ram_rd_data,
    output logic                  o_ram_wr_en,
    output logic [RAM_ADDR_W-1:0] o_ram_wr_addr,
    output logic [WORD_W-1:0]     o_ram_wr_data,
    output logic                  o_busy,
    output logic                  o_done
`ifdef HARQ_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0]  o_sat_count
`endif
);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  bank_q, bank_d;
    stage_t                s1_q, s1_d;
    stage_t                s2_q, s2_d;
    logic                  wr1_valid_q, wr1_valid_d;
    logic [RAM_ADDR_W-1:0] wr1_addr_q, wr1_addr_d;
    logic [WORD_W-1:0]     wr1_data_q, wr1_data_d;

    logic                  accept;
    logic                  s2_hit;
    logic                  wr1_hit;
    logic [WORD_W-1:0]     old_word;
    logic [WORD_W-1:0]     sum_word;
    logic [LANES-1:0]      lane_sat;

    always_comb begin
        accept        = (state_q == ST_RUN) && i_data_valid;
        o_ram_rd_en   = accept && mode_q;
        o_ram_rd_addr = {bank_q, i_addr};
    end

    // The RAM is read-first: a read issued in the same cycle as a write, or one cycle before it,
    // returns stale data, so the two most recent writes are bypassed into S1. Newest wins.
    always_comb begin
        s2_hit   = s2_q.valid && (s2_q.addr == s1_q.addr);
        wr1_hit  = wr1_valid_q && (wr1_addr_q == s1_q.addr);
        old_word = i_ram_rd_data;
        if (s2_hit) begin
            old_word = s2_q.data;
        end else if (wr1_hit) begin
            old_word = wr1_data_q;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        llr_sat_add u_add (
            .i_old (old_word[k*LLR_W +: LLR_W]),
            .i_new (s1_q.data[k*LLR_W +: LLR_W]),
            .o_sum (sum_word[k*LLR_W +: LLR_W]),
            .o_sat (lane_sat[k])
        );
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    mode_d  = i_mode_combine;
                    bank_d  = i_pingpong;
                end
            end
            ST_RUN: begin
                if (accept && i_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Nothing is accepted after the last word, so its write empties the pipeline.
                if (s2_q.valid && s2_q.last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = accept;
        if (accept) begin
            s1_d.last = i_last;
            s1_d.addr = {bank_q, i_addr};
            s1_d.data = i_data;
        end

        s2_d       = s2_q;
        s2_d.valid = s1_q.valid;
        if (s1_q.valid) begin
            s2_d.last = s1_q.last;
            s2_d.addr = s1_q.addr;
            s2_d.data = mode_q ? sum_word : s1_q.data;
        end

        wr1_valid_d = s2_q.valid;
        wr1_addr_d  = wr1_addr_q;
        wr1_data_d  = wr1_data_q;
        if (s2_q.valid) begin
            wr1_addr_d = s2_q.addr;
            wr1_data_d = s2_q.data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            bank_q      <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            wr1_valid_q <= 1'b0;
            wr1_addr_q  <= '0;
            wr1_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bank_q      <= bank_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            wr1_valid_q <= wr1_valid_d;
            wr1_addr_q  <= wr1_addr_d;
            wr1_data_q  <= wr1_data_d;
        end
    end

    always_comb begin
        o_ram_wr_en   = s2_q.valid;
        o_ram_wr_addr = s2_q.addr;
        o_ram_wr_data = s2_q.data;
        o_done        = s2_q.valid && s2_q.last;
        o_busy        = (state_q != ST_IDLE);
    end

`ifdef HARQ_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    // A word is counted once, as it leaves S1, if any lane clamped during a combine.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if ((state_q == ST_IDLE) && i_start) begin
            sat_cnt_d = '0;
        end else if (s1_q.valid && mode_q && (|lane_sat) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_count = sat_cnt_q;
`else
    logic sat_unused;
    assign sat_unused = |lane_sat;
`endif

endmodule
